// File: rtl/rom_arbiter_if.sv
// Bus between rom_arbiter and its environment: requester handshake plus shared ROM port.
// master = requesters and ROM model, slave = the arbiter.
interface rom_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int AW    = 12,
    parameter int DW    = 12
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    lock;
    logic [N_REQ*AW-1:0] addr;
    logic [N_REQ-1:0]    gnt;
    logic [AW-1:0]       rom_addr;
    logic                rom_en;
    logic [DW-1:0]       rom_data;
    logic [N_REQ-1:0]    rd_valid;
    logic [DW-1:0]       rd_data;
    logic                busy;

    modport master (
        output req, lock, addr, rom_data,
        input  gnt, rom_addr, rom_en, rd_valid, rd_data, busy
    );

    modport slave (
        input  req, lock, addr, rom_data,
        output gnt, rom_addr, rom_en, rd_valid, rd_data, busy
    );
endinterface

// File: rtl/rom_arbiter.sv
// Shared-ROM arbiter: round-robin grant with lock-driven bursts and a tag pipeline for read returns.
// Define ROM_ARBITER_FIXED_PRIO_EN to make idle arbitration fixed priority (lowest index wins).
module rom_arbiter #(
    parameter int N_REQ     = 4,
    parameter int AW        = 12,
    parameter int DW        = 12,
    parameter int RD_LAT    = 2,
    parameter int MAX_BURST = 8
) (
    input logic          clk,
    input logic          rst,
    rom_arbiter_if.slave bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

    typedef enum logic {IDLE, BURST} state_t;

    typedef struct packed {
        logic          valid;
        logic [IW-1:0] idx;
    } tag_t;

    state_t           state;
    logic [IW-1:0]    last_winner;
    logic [IW-1:0]    owner;
    logic [7:0]       burst_cnt;
    logic [AW-1:0]    addr_q;
    tag_t             tags [RD_LAT];

    logic             found;
    logic [IW-1:0]    win;
    logic [N_REQ-1:0] gnt;
    logic [AW-1:0]    sel_addr;
    logic             inflight;
    logic [N_REQ-1:0] rd_valid;

    // Grant is combinational so a request is accepted in the cycle it is presented.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        found = 1'b0;
        win   = '0;
        if (rst) begin
            if (state == BURST) begin
                found = bus.req[owner];
                win   = owner;
            end else begin
`ifdef ROM_ARBITER_FIXED_PRIO_EN
                for (int i = N_REQ - 1; i >= 0; i--) begin
                    if (bus.req[i]) begin
                        found = 1'b1;
                        win   = IW'(i);
                    end
                end
`else
                // Scan backwards so the candidate nearest last_winner+1 is written last and wins.
                for (int k = N_REQ; k >= 1; k--) begin
                    if (bus.req[(int'(last_winner) + k) % N_REQ]) begin
                        found = 1'b1;
                        win   = IW'((int'(last_winner) + k) % N_REQ);
                    end
                end
`endif
            end
        end
        gnt = '0;
        if (found) gnt[win] = 1'b1;
    end

    assign sel_addr = bus.addr[int'(win)*AW +: AW];

    always_comb begin
        inflight = 1'b0;
        for (int s = 0; s < RD_LAT; s++) inflight = inflight | tags[s].valid;
        rd_valid = '0;
        if (tags[RD_LAT-1].valid) rd_valid[tags[RD_LAT-1].idx] = 1'b1;
    end

    assign bus.gnt      = gnt;
    assign bus.rom_en   = found;
    assign bus.rom_addr = found ? sel_addr : addr_q;
    assign bus.rd_valid = rd_valid;
    assign bus.rd_data  = tags[RD_LAT-1].valid ? bus.rom_data : '0;
    assign bus.busy     = (state == BURST) | inflight | found;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_winner <= IW'(N_REQ - 1);
            owner       <= '0;
            burst_cnt   <= '0;
            addr_q      <= '0;
            // NOTE: the tag pipeline is reset on purpose; stale tags would emit rd_valid after reset.
            for (int s = 0; s < RD_LAT; s++) tags[s] <= '0;
        end else begin
            // NOTE: non-blocking throughout, so tags[s-1] below is the pre-edge value.
            tags[0] <= tag_t'{valid: found, idx: win};
            for (int s = 1; s < RD_LAT; s++) tags[s] <= tags[s-1];

            if (found) begin
                last_winner <= win;
                addr_q      <= sel_addr;
            end

            case (state)
                IDLE: begin
                    if (found && bus.lock[win] && MAX_BURST > 1) begin
                        state     <= BURST;
                        owner     <= win;
                        burst_cnt <= 8'd1;
                    end
                end
                BURST: begin
                    if (found && burst_cnt != 8'hFF) burst_cnt <= burst_cnt + 8'd1;
                    if (!bus.lock[owner] || (found && (burst_cnt + 8'd1) >= MAX_CNT))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: grant checks per cycle, read returns matched via a scoreboard queue.
// Expected grant orders follow ROM_ARBITER_FIXED_PRIO_EN when it is defined.
`timescale 1ns/1ps
module tb_rom_arbiter;
    localparam int N_REQ     = 4;
    localparam int AW        = 12;
    localparam int DW        = 12;
    localparam int RD_LAT    = 2;
    localparam int MAX_BURST = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rom_arbiter_if #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) bus ();

    rom_arbiter #(
        .N_REQ(N_REQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        int            due;
    } exp_rd_t;

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    exp_rd_t       sb [$];
    logic [AW-1:0] a_tab [N_REQ];
    logic [AW-1:0] last_addr;
    logic [DW-1:0] rom_pipe [RD_LAT];
    logic          b;

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        return a ^ 12'hA5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ROM model with RD_LAT cycles of latency.
    always @(posedge clk) begin
        rom_pipe[0] <= bus.rom_en ? rom_fn(bus.rom_addr) : '0;
        for (int k = 1; k < RD_LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
    end
    assign bus.rom_data = rom_pipe[RD_LAT-1];

    // Read-return monitor: rd_valid must appear exactly on the due cycle of the oldest entry.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            check("rd_valid", 32'(bus.rd_valid), 32'(1) << sb[0].idx);
            check("rd_data", 32'(bus.rd_data), 32'(sb[0].data));
            void'(sb.pop_front());
        end else begin
            check("rd_quiet", 32'(bus.rd_valid), 32'd0);
        end
    end

    task automatic set_addr(input int i, input logic [AW-1:0] v);
        a_tab[i] = v;
        bus.addr[i*AW +: AW] = v;
    endtask

    // Drive one cycle from posedge+1, check at negedge, return at the next posedge+1.
    task automatic run_cycle(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] l,
                             input int want, input string tag, output logic busy_seen);
        logic [AW-1:0] ea;
        bus.req  = r;
        bus.lock = l;
        @(negedge clk);
        ea = (want < 0) ? last_addr : a_tab[want];
        check({tag, "_gnt"}, 32'(bus.gnt), (want < 0) ? 32'd0 : (32'(1) << want));
        check({tag, "_en"}, 32'(bus.rom_en), (want < 0) ? 32'd0 : 32'd1);
        check({tag, "_addr"}, 32'(bus.rom_addr), 32'(ea));
        busy_seen = bus.busy;
        if (want >= 0) begin
            sb.push_back('{idx: want, data: rom_fn(ea), due: cyc + RD_LAT});
            last_addr = ea;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        bus.req   = '0;
        bus.lock  = '0;
        bus.addr  = '0;
        last_addr = '0;
        for (int i = 0; i < N_REQ; i++) set_addr(i, AW'(16 * (i + 1)));

        // Reset state with every requester asserting
        bus.req = '1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_en", 32'(bus.rom_en), 32'd0);
        check("rst_addr", 32'(bus.rom_addr), 32'd0);
        check("rst_rdv", 32'(bus.rd_valid), 32'd0);
        check("rst_rdd", 32'(bus.rd_data), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // All four at once, each drops after its grant
        run_cycle(4'b1111, 4'b0000, 0, "all0", b);
        run_cycle(4'b1110, 4'b0000, 1, "all1", b);
        run_cycle(4'b1100, 4'b0000, 2, "all2", b);
        run_cycle(4'b1000, 4'b0000, 3, "all3", b);
        run_cycle(4'b0000, 4'b0000, -1, "all_done", b);

        // Single requester 3 with busy tracking across the read
        set_addr(3, 12'hABC);
        run_cycle(4'b1000, 4'b0000, 3, "single", b);
        check("single_busy0", 32'(b), 32'd1);
        run_cycle(4'b0000, 4'b0000, -1, "single_w1", b);
        check("single_busy1", 32'(b), 32'd1);
        run_cycle(4'b0000, 4'b0000, -1, "single_w2", b);
        check("single_busy2", 32'(b), 32'd1);
        run_cycle(4'b0000, 4'b0000, -1, "single_w3", b);
        check("single_busy3", 32'(b), 32'd0);

        // Burst cap: requester 2 locks while 0 keeps requesting
        run_cycle(4'b0100, 4'b0100, 2, "burst_start", b);
        check("burst_busy", 32'(b), 32'd1);
        for (int i = 0; i < MAX_BURST - 1; i++) run_cycle(4'b0101, 4'b0100, 2, "burst", b);
        run_cycle(4'b0101, 4'b0100, 0, "burst_yield", b);
        for (int i = 0; i < 3; i++) begin
`ifdef ROM_ARBITER_FIXED_PRIO_EN
            run_cycle(4'b0101, 4'b0100, 0, "burst_after", b);
`else
            run_cycle(4'b0101, 4'b0100, 2, "burst_resume", b);
`endif
        end
        run_cycle(4'b0000, 4'b0000, -1, "burst_unlock", b);

        // Owner 1 pauses its requests while holding lock; 3 must not get in
        run_cycle(4'b0010, 4'b0010, 1, "hold_start", b);
        for (int i = 0; i < 3; i++) run_cycle(4'b1000, 4'b0010, -1, "hold_gap", b);
        run_cycle(4'b1010, 4'b0010, 1, "hold_back", b);
        run_cycle(4'b1000, 4'b0000, -1, "hold_release", b);
        run_cycle(4'b1000, 4'b0000, 3, "hold_other", b);
        run_cycle(4'b0000, 4'b0000, -1, "hold_done", b);

        // Constant req=1010
        for (int i = 0; i < 6; i++) begin
`ifdef ROM_ARBITER_FIXED_PRIO_EN
            run_cycle(4'b1010, 4'b0000, 1, "prio", b);
`else
            run_cycle(4'b1010, 4'b0000, (i % 2 == 0) ? 1 : 3, "rr", b);
`endif
        end

        // Reset with two reads in flight: both must vanish, then index 0 wins first
        run_cycle(4'b0001, 4'b0000, 0, "fly0", b);
        run_cycle(4'b0010, 4'b0000, 1, "fly1", b);
        rst = 1'b0;
        sb.delete();
        last_addr = '0;
        for (int i = 0; i < 3; i++) begin
            run_cycle(4'b1111, 4'b0000, -1, "in_rst", b);
            check("in_rst_busy", 32'(b), 32'd0);
        end
        rst = 1'b1;
        run_cycle(4'b1111, 4'b0000, 0, "post_rst", b);
        for (int i = 0; i < RD_LAT + 2; i++) run_cycle(4'b0000, 4'b0000, -1, "drain", b);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 The block SHALL have parameter AW, default 12, ROM address width.
REQ-003 The block SHALL have parameter DW, default 12, ROM data width (one RGB pixel).
REQ-004 The block SHALL have parameter RD_LAT, default 2, ROM read latency in cycles (1..4).
REQ-005 The block SHALL have parameter MAX_BURST, default 8, maximum consecutive grants under lock (1..255).
REQ-006 The block SHALL have port clk, input, 1, single system clock, rising edge.
REQ-007 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have port req, input, N_REQ, per-requester read request.
REQ-009 The block SHALL have port lock, input, N_REQ, per-requester burst-hold request.
REQ-010 The block SHALL have port addr, input, N_REQ*AW, packed addresses, requester i at bits [i*AW +: AW].
REQ-011 The block SHALL have port gnt, output, N_REQ, one-hot grant, request accepted this cycle.
REQ-012 The block SHALL have port rom_addr, output, AW, shared ROM address.
REQ-013 The block SHALL have port rom_en, output, 1, ROM read enable.
REQ-014 The block SHALL have port rom_data, input, DW, ROM read data, valid RD_LAT cycles after rom_en.
REQ-015 The block SHALL have port rd_valid, output, N_REQ, one-hot data-return strobe.
REQ-016 The block SHALL have port rd_data, output, DW, returned data, qualified by rd_valid.
REQ-017 The block SHALL have port busy, output, 1, high while in BURST state or any read is in flight.

Function
REQ-018 gnt SHALL be combinational from req and registered state; at most one bit high; gnt[i] implies req[i].
REQ-019 In the cycle gnt[i] is high, rom_en SHALL be 1 and rom_addr SHALL equal addr[i]; otherwise rom_en SHALL be 0 and rom_addr SHALL hold its last value.
REQ-020 A requester SHALL hold req[i] and addr[i] stable until it sees gnt[i]; one grant consumes one request cycle.
REQ-021 rd_valid[i] SHALL pulse exactly RD_LAT cycles after gnt[i], with rd_data equal to rom_data in that cycle, via an RD_LAT-deep requester-tag pipeline.
REQ-022 FSM states SHALL be IDLE and BURST only.
REQ-023 IDLE: grant the first requesting index searching from (last_winner+1) mod N_REQ upward (round-robin); no request gives no grant.
REQ-024 IDLE->BURST when the granted requester also has lock[i]=1; owner:=i, burst_cnt:=1.
REQ-025 BURST: only owner is eligible; each owner grant increments burst_cnt.
REQ-026 BURST->IDLE when lock[owner]=0, or when burst_cnt reaches MAX_BURST at an owner grant; the next cycle arbitrates round-robin from owner+1.
REQ-027 In BURST, owner req=0 with lock=1 SHALL yield no grant, and SHALL NOT grant other requesters.
REQ-028 last_winner SHALL update on every grant; burst_cnt SHALL be 8 bits and SHALL NOT wrap.
REQ-029 Simultaneous requests from all N_REQ with lock=0 SHALL be served in N_REQ consecutive cycles, one each.

Reset
REQ-030 On rst=0, asynchronously: state=IDLE, last_winner=N_REQ-1 (index 0 wins first), burst_cnt=0, tag pipeline cleared.
REQ-031 During and after reset: gnt=0, rom_en=0, rom_addr=0, rd_valid=0, rd_data=0, busy=0; in-flight reads at reset SHALL be dropped, with no rd_valid.

Configuration
REQ-032 Macro ROM_ARBITER_FIXED_PRIO_EN defined: IDLE arbitration SHALL be fixed priority, lowest index wins; burst rules unchanged.
REQ-033 Macro undefined: round-robin per REQ-023.

Verification
REQ-034 req=4'b1111, lock=0, addrs 0x010/0x020/0x030/0x040 -> gnt order 0,1,2,3 on consecutive cycles; rd_valid same order RD_LAT=2 cycles later.
REQ-035 req[2]=1, lock[2]=1 held 12 cycles, req[0]=1 throughout -> 8 grants to 2, then gnt[0], then 2 resumes.
REQ-036 Owner 1 in BURST drops req for 3 cycles, lock held, req[3]=1 -> no grant for 3 cycles, then gnt[1].
REQ-037 rst low with 2 reads in flight -> rd_valid never asserts for them; after release, first grant goes to index 0.
REQ-038 With ROM_ARBITER_FIXED_PRIO_EN, req=4'b1010 held constant -> gnt[1] every cycle, gnt[3] never.
REQ-039 Single req[3], addr=0xABC -> gnt[3] and rom_addr=0xABC same cycle; rd_valid[3] with rom_data 2 cycles later; busy high across those cycles.
